// File: rtl/clk_mon_pkg.sv
// Shared constants for the clock-rate monitor: FSM encoding, default window
// parameters and the tolerance lower-bound helper.
package clk_mon_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;
    localparam logic [1:0] ST_FAULT   = 2'd3;

    localparam int DEF_WIN_LEN   = 256;
    localparam int DEF_EXP_EDGES = 128;
    localparam int DEF_TOL       = 2;
    localparam int DEF_LOCK_CNT  = 4;

    // Lower edge of the good band, clamped at zero so a wide tolerance never wraps.
    function automatic int tol_lo(input int exp_edges, input int tol);
        return (exp_edges > tol) ? (exp_edges - tol) : 0;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Three-flop synchronizer for a slow clock sampled as data, with a
// one-cycle rising-edge detect taken from the two settled stages.
module edge_sync (
    input  logic clk_clk,
    input  logic rst_clk_n,
    input  logic d_in,
    output logic rise
);

    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    always_comb begin
        s1_d = d_in;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk_clk or negedge rst_clk_n) begin
        if (!rst_clk_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every stage loads its pre-edge neighbour; blocking here would collapse the chain into one flop.
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    // s1 may be metastable; only s2/s3 feed the edge detect.
    assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/clk_rate_monitor.sv
// Counts rising edges of a divided clock per fixed window of clk_clk cycles
// and tracks lock/loss of that clock; rise_pulse serves as a clock enable.
module clk_rate_monitor
    import clk_mon_pkg::*;
#(
    parameter int WIN_LEN   = DEF_WIN_LEN,
    parameter int EXP_EDGES = DEF_EXP_EDGES,
    parameter int TOL       = DEF_TOL,
    parameter int LOCK_CNT  = DEF_LOCK_CNT,
    parameter int CNT_W     = $clog2(WIN_LEN + 1)
) (
    input  logic             clk_clk,
    input  logic             rst_clk_n,
    input  logic             mon_clk,
    input  logic             en,
    output logic             rise_pulse,
    output logic [CNT_W-1:0] edge_cnt,
    output logic             win_done,
    output logic             locked,
    output logic             fault
);

    localparam int WIN_W  = $clog2(WIN_LEN);
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);

    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W:0]    GOOD_LO   = (CNT_W + 1)'(tol_lo(EXP_EDGES, TOL));
    localparam logic [CNT_W:0]    GOOD_HI   = (CNT_W + 1)'(EXP_EDGES + TOL);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);

    logic rise_raw;

    edge_sync u_edge_sync (
        .clk_clk   (clk_clk),
        .rst_clk_n (rst_clk_n),
        .d_in      (mon_clk),
        .rise      (rise_raw)
    );

    assign rise_pulse = rise_raw & en;

    logic [1:0]        state_q,    state_d;
    logic [WIN_W-1:0]  win_cnt_q,  win_cnt_d;
    logic [CNT_W-1:0]  ecnt_q,     ecnt_d;
    logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
    logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
    logic              fault_q,    fault_d;

    logic              active;
    logic              win_end;
    logic [CNT_W:0]    total;
    logic [CNT_W-1:0]  total_sat;
    logic              good;

    always_comb begin
        active    = (state_q != ST_IDLE);
        win_end   = active && en && (win_cnt_q == WIN_LAST);
        // One extra bit so the closing-cycle pulse and the band compare cannot wrap.
        total     = {1'b0, ecnt_q} + (CNT_W + 1)'(rise_pulse);
        total_sat = total[CNT_W] ? CNT_MAX : total[CNT_W-1:0];
        good      = (total >= GOOD_LO) && (total <= GOOD_HI);

        // NOTE: every _d starts from its _q so no path leaves a target unassigned and infers a latch.
        state_d    = state_q;
        win_cnt_d  = win_cnt_q;
        ecnt_d     = ecnt_q;
        edge_cnt_d = edge_cnt_q;
        good_cnt_d = good_cnt_q;
        fault_d    = fault_q;

        if (!en) begin
            state_d    = ST_IDLE;
            win_cnt_d  = '0;
            ecnt_d     = '0;
            edge_cnt_d = '0;
            good_cnt_d = '0;
            fault_d    = 1'b0;
        end else if (!active) begin
            state_d   = ST_MEASURE;
            win_cnt_d = '0;
            ecnt_d    = '0;
        end else if (win_end) begin
            win_cnt_d  = '0;
            ecnt_d     = '0;
            edge_cnt_d = total_sat;
            if (state_q == ST_LOCKED) begin
                if (!good) begin
                    state_d    = ST_FAULT;
                    fault_d    = 1'b1;
                    good_cnt_d = '0;
                end
            end else if (good) begin
                // MEASURE and FAULT share the run-length count; fault stays sticky across relock.
                if (good_cnt_q == GOOD_LAST) begin
                    state_d    = ST_LOCKED;
                    good_cnt_d = '0;
                end else begin
                    good_cnt_d = good_cnt_q + GOOD_W'(1);
                end
            end else begin
                good_cnt_d = '0;
            end
        end else begin
            win_cnt_d = win_cnt_q + WIN_W'(1);
            if (rise_pulse && (ecnt_q != CNT_MAX)) begin
                ecnt_d = ecnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_clk or negedge rst_clk_n) begin
        if (!rst_clk_n) begin
            state_q    <= ST_IDLE;
            win_cnt_q  <= '0;
            ecnt_q     <= '0;
            edge_cnt_q <= '0;
            good_cnt_q <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_cnt_q  <= win_cnt_d;
            ecnt_q     <= ecnt_d;
            edge_cnt_q <= edge_cnt_d;
            good_cnt_q <= good_cnt_d;
            fault_q    <= fault_d;
        end
    end

    assign edge_cnt = edge_cnt_q;
    assign win_done = win_end;
    assign locked   = (state_q == ST_LOCKED);
    assign fault    = fault_q;

endmodule

// File: tb/tb_clk_rate_monitor.sv
// Directed bench for clk_rate_monitor: a default instance plus a narrow-band
// instance (EXP_EDGES=126, TOL=1, LOCK_CNT=1) that exposes both band edges.
module tb_clk_rate_monitor;

    logic       clk_clk = 1'b0;
    logic       rst_clk_n;
    logic       mon_clk;
    logic       en;
    logic       en2;

    logic       rise_pulse, win_done, locked, fault;
    logic [8:0] edge_cnt;
    logic       rise_pulse2, win_done2, locked2, fault2;
    logic [8:0] edge_cnt2;

    int checks   = 0;
    int failures = 0;

    always #5 clk_clk = ~clk_clk;

    clk_rate_monitor #(
        .WIN_LEN(256), .EXP_EDGES(128), .TOL(2), .LOCK_CNT(4)
    ) u_dut (
        .clk_clk    (clk_clk),
        .rst_clk_n  (rst_clk_n),
        .mon_clk    (mon_clk),
        .en         (en),
        .rise_pulse (rise_pulse),
        .edge_cnt   (edge_cnt),
        .win_done   (win_done),
        .locked     (locked),
        .fault      (fault)
    );

    clk_rate_monitor #(
        .WIN_LEN(256), .EXP_EDGES(126), .TOL(1), .LOCK_CNT(1)
    ) u_dut2 (
        .clk_clk    (clk_clk),
        .rst_clk_n  (rst_clk_n),
        .mon_clk    (mon_clk),
        .en         (en2),
        .rise_pulse (rise_pulse2),
        .edge_cnt   (edge_cnt2),
        .win_done   (win_done2),
        .locked     (locked2),
        .fault      (fault2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic expect1(input string tag, input int e, input bit l, input bit f);
        check({tag, "_edge_cnt"}, 32'(edge_cnt), e);
        check({tag, "_locked"},   32'(locked),   32'(l));
        check({tag, "_fault"},    32'(fault),    32'(f));
    endtask

    task automatic expect2(input string tag, input int e, input bit l, input bit f);
        check({tag, "_edge_cnt2"}, 32'(edge_cnt2), e);
        check({tag, "_locked2"},   32'(locked2),   32'(l));
        check({tag, "_fault2"},    32'(fault2),    32'(f));
    endtask

    // Called #1 after a rising edge: drive mon_clk for this cycle, then advance.
    task automatic step(input logic v);
        mon_clk = v;
        @(posedge clk_clk);
        #1;
    endtask

    // Window-relative drive value. Own rises at odd j (1..2m-1) land as pulses
    // two cycles later, still inside the window; a tail rise at j=255 lands in
    // the next window's cycle 1; a late rise at j=253 lands on the window-end cycle.
    function automatic logic pat(input int j, input int m, input bit tail,
                                 input bit late, input bit div4);
        logic v;
        v = 1'b0;
        if (div4) begin
            v = ((j % 4) == 1) || ((j % 4) == 2);
        end else begin
            if (((j % 2) == 1) && (j <= 2 * m - 1)) v = 1'b1;
            if (tail && (j == 255)) v = 1'b1;
            if (late && (j == 253)) v = 1'b1;
        end
        return v;
    endfunction

    task automatic run_window(input string tag, input int m, input bit tail,
                              input bit late, input bit div4, input bit sel);
        int wd;
        wd = 0;
        for (int j = 0; j < 256; j++) begin
            wd += sel ? int'(win_done2) : int'(win_done);
            step(pat(j, m, tail, late, div4));
        end
        check({tag, "_win_done_count"}, wd, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_clk_n = 1'b0;
        en        = 1'b0;
        en2       = 1'b0;
        mon_clk   = 1'b0;

        // Reset state.
        #12;
        expect1("rst", 0, 0, 0);
        check("rst_rise_pulse", 32'(rise_pulse), 0);
        check("rst_win_done",   32'(win_done),   0);
        @(posedge clk_clk);
        #1;
        rst_clk_n = 1'b1;
        repeat (3) step(1'b0);
        expect1("idle", 0, 0, 0);

        // Divide-by-2 toggle: lock at the 4th window end.
        en = 1'b1;
        step(1'b1);
        run_window("a_w1", 127, 1, 0, 0, 0);  expect1("a_w1", 128, 0, 0);
        run_window("a_w2", 127, 1, 0, 0, 0);  expect1("a_w2", 128, 0, 0);
        run_window("a_w3", 127, 1, 0, 0, 0);  expect1("a_w3", 128, 0, 0);
        run_window("a_w4", 127, 0, 0, 0, 0);  expect1("a_w4", 128, 1, 0);

        // Stuck low after lock, then recovery with fault held.
        run_window("a_stuck", 0, 0, 0, 0, 0); expect1("a_stuck", 0, 0, 1);
        run_window("a_r1", 127, 1, 0, 0, 0);  expect1("a_r1", 127, 0, 1);
        run_window("a_r2", 127, 1, 0, 0, 0);  expect1("a_r2", 128, 0, 1);
        run_window("a_r3", 127, 1, 0, 0, 0);  expect1("a_r3", 128, 0, 1);
        run_window("a_r4", 127, 0, 0, 0, 0);  expect1("a_r4", 128, 1, 1);

        // One-cycle en drop mid-window: pulse is gated, state and fault clear.
        for (int j = 0; j < 101; j++) step(logic'(j % 2));
        check("b_pulse_en1", 32'(rise_pulse), 1);
        en = 1'b0;
        #1;
        check("b_pulse_gated", 32'(rise_pulse), 0);
        step(1'b0);
        expect1("b_idle", 0, 0, 0);
        check("b_idle_win_done", 32'(win_done), 0);
        en = 1'b1;
        step(1'b0);
        run_window("b_fresh", 100, 0, 0, 0, 0); expect1("b_fresh", 100, 0, 0);

        // Lower band edge in MEASURE; a bad window resets the good run.
        run_window("c1", 126, 0, 0, 0, 0); expect1("c1", 126, 0, 0);
        run_window("c2", 127, 0, 0, 0, 0); expect1("c2", 127, 0, 0);
        run_window("c3", 125, 0, 0, 0, 0); expect1("c3", 125, 0, 0);
        run_window("c4", 127, 1, 0, 0, 0); expect1("c4", 127, 0, 0);
        run_window("c5", 127, 1, 0, 0, 0); expect1("c5", 128, 0, 0);
        run_window("c6", 127, 0, 0, 0, 0); expect1("c6", 128, 0, 0);
        run_window("c7", 126, 0, 0, 0, 0); expect1("c7", 126, 1, 0);

        // Asynchronous reset mid-window while locked.
        for (int j = 0; j < 50; j++) step(logic'(j % 2));
        rst_clk_n = 1'b0;
        #1;
        expect1("e_rst", 0, 0, 0);
        check("e_rst_win_done", 32'(win_done), 0);
        check("e_rst_rise",     32'(rise_pulse), 0);
        en      = 1'b0;
        mon_clk = 1'b0;
        repeat (2) @(posedge clk_clk);
        #1;
        rst_clk_n = 1'b1;
        step(1'b0);
        step(1'b0);

        // Single edge whose pulse lands on the window-end cycle.
        en = 1'b1;
        step(1'b0);
        run_window("d_late", 0, 0, 1, 0, 0); expect1("d_late", 1, 0, 0);
        run_window("d_next", 0, 0, 0, 0, 0); expect1("d_next", 0, 0, 0);

        // Divide-by-4 from a fresh start: never locks, never faults.
        en = 1'b0;
        step(1'b0);
        en = 1'b1;
        step(1'b0);
        run_window("g1", 0, 0, 0, 1, 0); expect1("g1", 64, 0, 0);
        run_window("g2", 0, 0, 0, 1, 0); expect1("g2", 64, 0, 0);
        run_window("g3", 0, 0, 0, 1, 0); expect1("g3", 64, 0, 0);

        // Narrow-band instance: both band edges, relock keeps fault.
        en = 1'b0;
        step(1'b0);
        expect1("f_dut1_off", 0, 0, 0);
        expect2("f_idle", 0, 0, 0);
        en2 = 1'b1;
        step(1'b0);
        run_window("f1", 126, 1, 0, 0, 1); expect2("f1", 126, 1, 0);
        run_window("f2", 127, 0, 0, 0, 1); expect2("f2", 128, 0, 1);
        run_window("f3", 125, 0, 0, 0, 1); expect2("f3", 125, 1, 1);
        run_window("f4", 124, 0, 0, 0, 1); expect2("f4", 124, 0, 1);
        run_window("f5", 127, 0, 0, 0, 1); expect2("f5", 127, 1, 1);
        en2 = 1'b0;
        step(1'b0);
        expect2("f_off", 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
